// File: rtl/uart_poll_sequencer_if.sv
// ---------------------------------------------------------------------------
// uart_poll_sequencer_if
// Native iob_uart register port, as seen from the bus master.
//
// Handshake: the master raises uart_valid together with uart_addr, uart_wdata
// and uart_wstrb (wstrb == 0 means read) and holds all four stable until it
// samples uart_ready high; uart_ready is a single-cycle completion pulse and
// uart_rdata is only meaningful in that cycle. At most one request is
// outstanding.
//
// Signals:
//   uart_valid  master->slave  request active
//   uart_addr   master->slave  register address (ADDR_W)
//   uart_wdata  master->slave  write data (DATA_W)
//   uart_wstrb  master->slave  byte strobes (DATA_W/8), 0 = read
//   uart_rdata  slave->master  read data (DATA_W)
//   uart_ready  slave->master  transaction-complete pulse
// ---------------------------------------------------------------------------
interface uart_poll_sequencer_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  logic                  uart_valid;
  logic [ADDR_W-1:0]     uart_addr;
  logic [DATA_W-1:0]     uart_wdata;
  logic [DATA_W/8-1:0]   uart_wstrb;
  logic [DATA_W-1:0]     uart_rdata;
  logic                  uart_ready;

  modport master (
    output uart_valid, uart_addr, uart_wdata, uart_wstrb,
    input  uart_rdata, uart_ready
  );

  modport slave (
    input  uart_valid, uart_addr, uart_wdata, uart_wstrb,
    output uart_rdata, uart_ready
  );
endinterface

// File: rtl/uart_poll_sequencer.sv
// ---------------------------------------------------------------------------
// uart_poll_sequencer
// Bus master that initialises an iob_uart (soft reset pulse, baud divider,
// TX/RX enable) and then polls it forever, alternating one RX slot and one
// TX slot so neither direction can starve the other. Received bytes land in
// a one-entry output buffer (rx_data_o/rx_valid_o/rx_ready_i); bytes offered
// on tx_data_i/tx_valid_i are written to TXDATA and acknowledged with a
// single-cycle tx_ready_o pulse.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   cfg_div_i      16-bit baud divider, sampled when the DIV write starts
//   init_done_o    high once the configuration writes have completed
//   bus            uart_poll_sequencer_if.master (UART register port)
//   rx_data_o/rx_valid_o/rx_ready_i   received byte stream
//   tx_data_i/tx_valid_i/tx_ready_o   transmit byte stream
//   bus_err_o      sticky bus-timeout flag (0 unless timeout is compiled in)
//   dbg_state_o    current FSM state encoding
//
// Lane placement: lane = addr[1:0]; writes shift data by 8*lane and strobes
// by lane; reads shift rdata right by 8*lane, flags use bit 0 of the result.
//
// Optional feature macro: UART_POLL_TIMEOUT_EN. When defined, a request that
// sees no uart_ready within TIMEOUT cycles is dropped, bus_err_o is set, and
// the FSM resumes at POLL_RX (or restarts init at W_SRST1 if init is not
// done). A timed-out read counts as flag 0.
// ---------------------------------------------------------------------------
module uart_poll_sequencer #(
  parameter int ADDR_W         = 3,
  parameter int DATA_W         = 32,
  parameter int SOFTRESET_ADDR = 0,
  parameter int DIV_ADDR       = 2,
  parameter int TXDATA_ADDR    = 4,
  parameter int TXEN_ADDR      = 5,
  parameter int RXEN_ADDR      = 6,
  parameter int TXREADY_ADDR   = 0,
  parameter int RXREADY_ADDR   = 1,
  parameter int RXDATA_ADDR    = 4,
  parameter int TIMEOUT        = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         cfg_div_i,
  output logic                init_done_o,
  uart_poll_sequencer_if.master bus,
  output logic [7:0]          rx_data_o,
  output logic                rx_valid_o,
  input  logic                rx_ready_i,
  input  logic [7:0]          tx_data_i,
  input  logic                tx_valid_i,
  output logic                tx_ready_o,
  output logic                bus_err_o,
  output logic [3:0]          dbg_state_o
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [3:0] {
    W_SRST1 = 4'd0,
    W_SRST0 = 4'd1,
    W_DIV   = 4'd2,
    W_TXEN  = 4'd3,
    W_RXEN  = 4'd4,
    POLL_RX = 4'd5,
    RD_RX   = 4'd6,
    POLL_TX = 4'd7,
    WR_TX   = 4'd8
  } state_t;

  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                init_done_q, init_done_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                tx_ready_q, tx_ready_d;

  // Request being launched this cycle (unshifted; lane placement is common).
  logic                req_en;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_data;
  logic [STRB_W-1:0]   req_mask;

  logic                done;
  logic [DATA_W-1:0]   rd_val;
  logic                flag;

`ifdef UART_POLL_TIMEOUT_EN
  logic [15:0]         timer_q, timer_d;
  logic                bus_err_q, bus_err_d;
  logic                timeout;
`endif

  assign done   = valid_q & bus.uart_ready;
  assign rd_val = bus.uart_rdata >> {addr_q[1:0], 3'b000};
  assign flag   = rd_val[0];

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    init_done_d = init_done_q;
    rx_data_d   = rx_data_q;
    // Consumer handshake frees the buffer; a load below overrides this.
    rx_valid_d  = rx_valid_q & ~rx_ready_i;
    tx_ready_d  = 1'b0;
    req_en      = 1'b0;
    req_addr    = '0;
    req_data    = '0;
    req_mask    = '0;

    case (state_q)
      W_SRST1: begin
        if (!valid_q) begin
          req_en = 1'b1; req_addr = ADDR_W'(SOFTRESET_ADDR);
          req_data = DATA_W'(1); req_mask = STRB_W'(1);
        end else if (done) begin
          state_d = W_SRST0;
        end
      end
      W_SRST0: begin
        if (!valid_q) begin
          req_en = 1'b1; req_addr = ADDR_W'(SOFTRESET_ADDR);
          req_data = '0; req_mask = STRB_W'(1);
        end else if (done) begin
          state_d = W_DIV;
        end
      end
      W_DIV: begin
        if (!valid_q) begin
          req_en = 1'b1; req_addr = ADDR_W'(DIV_ADDR);
          req_data = DATA_W'(cfg_div_i); req_mask = STRB_W'(3);
        end else if (done) begin
          state_d = W_TXEN;
        end
      end
      W_TXEN: begin
        if (!valid_q) begin
          req_en = 1'b1; req_addr = ADDR_W'(TXEN_ADDR);
          req_data = DATA_W'(1); req_mask = STRB_W'(1);
        end else if (done) begin
          state_d = W_RXEN;
        end
      end
      W_RXEN: begin
        if (!valid_q) begin
          req_en = 1'b1; req_addr = ADDR_W'(RXEN_ADDR);
          req_data = DATA_W'(1); req_mask = STRB_W'(1);
        end else if (done) begin
          init_done_d = 1'b1;
          state_d     = POLL_RX;
        end
      end
      POLL_RX: begin
        if (!valid_q) begin
          // A full buffer means there is nowhere to put a byte: skip the read.
          if (rx_valid_q) begin
            state_d = POLL_TX;
          end else begin
            req_en = 1'b1; req_addr = ADDR_W'(RXREADY_ADDR);
          end
        end else if (done) begin
          state_d = flag ? RD_RX : POLL_TX;
        end
      end
      RD_RX: begin
        if (!valid_q) begin
          req_en = 1'b1; req_addr = ADDR_W'(RXDATA_ADDR);
        end else if (done) begin
          rx_data_d  = rd_val[7:0];
          rx_valid_d = 1'b1;
          state_d    = POLL_TX;
        end
      end
      POLL_TX: begin
        if (!valid_q) begin
          if (!tx_valid_i) begin
            state_d = POLL_RX;
          end else begin
            req_en = 1'b1; req_addr = ADDR_W'(TXREADY_ADDR);
          end
        end else if (done) begin
          state_d = flag ? WR_TX : POLL_RX;
        end
      end
      WR_TX: begin
        // tx_data_i is captured into the bus register here, so a client that
        // drops tx_valid_i mid-write does not disturb the transfer.
        if (!valid_q) begin
          req_en = 1'b1; req_addr = ADDR_W'(TXDATA_ADDR);
          req_data = DATA_W'(tx_data_i); req_mask = STRB_W'(1);
        end else if (done) begin
          tx_ready_d = 1'b1;
          state_d    = POLL_RX;
        end
      end
      default: begin
        state_d = W_SRST1;
        valid_d = 1'b0;
      end
    endcase

    if (req_en) begin
      valid_d = 1'b1;
      addr_d  = req_addr;
      wdata_d = req_data << {req_addr[1:0], 3'b000};
      wstrb_d = req_mask << req_addr[1:0];
    end else if (done) begin
      // Completion drops valid, which guarantees one idle cycle before
      // the next request.
      valid_d = 1'b0;
    end
  end

`ifdef UART_POLL_TIMEOUT_EN
  assign timeout = valid_q & ~bus.uart_ready & (timer_q == 16'(TIMEOUT - 1));

  always_comb begin
    timer_d   = valid_q ? timer_q + 16'd1 : 16'd0;
    bus_err_d = bus_err_q | timeout;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= W_SRST1;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      init_done_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_ready_q  <= 1'b0;
`ifdef UART_POLL_TIMEOUT_EN
      timer_q     <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      init_done_q <= init_done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_ready_q  <= tx_ready_d;
`ifdef UART_POLL_TIMEOUT_EN
      timer_q     <= timer_d;
      bus_err_q   <= bus_err_d;
      if (timeout) begin
        // Abandon the request; a stuck init restarts from the soft reset.
        valid_q <= 1'b0;
        state_q <= init_done_q ? POLL_RX : W_SRST1;
      end else begin
        valid_q <= valid_d;
        state_q <= state_d;
      end
`else
      valid_q     <= valid_d;
      state_q     <= state_d;
`endif
    end
  end

  assign bus.uart_valid = valid_q;
  assign bus.uart_addr  = addr_q;
  assign bus.uart_wdata = wdata_q;
  assign bus.uart_wstrb = wstrb_q;
  assign init_done_o    = init_done_q;
  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign tx_ready_o     = tx_ready_q;
  assign dbg_state_o    = state_q;
`ifdef UART_POLL_TIMEOUT_EN
  assign bus_err_o      = bus_err_q;
`else
  assign bus_err_o      = 1'b0;
`endif

endmodule

// File: doc/uart_poll_sequencer.md
Name: uart_poll_sequencer

Overview:
- Hardware bus master that configures an iob_uart through its native register interface, then polls it continuously.
- Moves received bytes to a byte stream output and transmits bytes taken from a byte stream input.
- Replaces software or bench polling loops (RXREADY/TXREADY/RXDATA/TXDATA) so a console byte path needs no CPU.
- Sits between a console/stream client and the UART's valid/addr/wdata/wstrb/rdata/ready port.

Parameters:
- ADDR_W, 3, UART register address width
- DATA_W, 32, UART bus data width
- SOFTRESET_ADDR, 0, write address of UART soft reset
- DIV_ADDR, 2, write address of 16-bit baud divider
- TXDATA_ADDR, 4, write address of TX byte
- TXEN_ADDR, 5, write address of TX enable
- RXEN_ADDR, 6, write address of RX enable
- TXREADY_ADDR, 0, read address of TX-ready flag
- RXREADY_ADDR, 1, read address of RX-ready flag
- RXDATA_ADDR, 4, read address of RX byte
- TIMEOUT, 1023, bus-timeout cycle limit (optional feature only)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cfg_div_i  in  16  baud divider; sampled once in W_DIV
- init_done_o  out  1  high once UART configuration has completed
- uart_valid  out  1  bus request
- uart_addr  out  ADDR_W  register address
- uart_wdata  out  DATA_W  write data
- uart_wstrb  out  DATA_W/8  byte strobes; 0 means read
- uart_rdata  in  DATA_W  read data; valid when uart_ready=1
- uart_ready  in  1  transaction-complete pulse
- rx_data_o  out  8  received byte
- rx_valid_o  out  1  rx_data_o valid
- rx_ready_i  in  1  consumer accepts the byte
- tx_data_i  in  8  byte to send
- tx_valid_i  in  1  tx_data_i valid
- tx_ready_o  out  1  one-cycle pulse; byte accepted
- bus_err_o  out  1  sticky timeout flag (optional feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs are 0. FSM enters W_SRST1.
- Reset mid-transaction: the transaction is abandoned. uart_valid is 0 at the reset edge, and the init sequence restarts.
- Bus rules:
  - At most one outstanding request.
  - uart_valid, uart_addr, uart_wdata and uart_wstrb are held stable until uart_ready is sampled high.
  - uart_valid drops in the cycle after ready, giving a minimum of 1 idle cycle between requests.
- Lane placement: lane = addr[1:0].
  - Byte write: wdata = byte << 8*lane, wstrb = 1 << lane.
  - DIV write: wdata = cfg_div_i << 8*lane, wstrb = 3 << lane.
  - Read: wstrb = 0; value = rdata >> 8*lane. Flag reads use bit 0 of that value.
- FSM, init sequence (each state is one bus write, advancing on ready):
  - W_SRST1: SOFTRESET = 1
  - W_SRST0: SOFTRESET = 0
  - W_DIV: DIV = cfg_div_i
  - W_TXEN: TXEN = 1
  - W_RXEN: RXEN = 1; on completion init_done_o goes 1 and the FSM enters POLL_RX.
- FSM, polling loop:
  - POLL_RX:
    - If rx_valid_o=1 (buffer full), skip directly to POLL_TX with no bus cycle.
    - Otherwise read RXREADY. Flag 1 goes to RD_RX; flag 0 goes to POLL_TX.
  - RD_RX: read RXDATA. On ready, latch the byte into rx_data_o, set rx_valid_o, then go to POLL_TX.
  - POLL_TX:
    - If tx_valid_i=0, go to POLL_RX with no bus cycle.
    - Otherwise read TXREADY. Flag 1 goes to WR_TX; flag 0 goes to POLL_RX.
  - WR_TX:
    - Write TXDATA = tx_data_i, captured into the bus register at request start.
    - On ready, pulse tx_ready_o for 1 cycle, then go to POLL_RX.
- RX/TX alternate strictly, so neither direction can starve the other.
- RX output buffer (1 entry):
  - Cleared when rx_valid_o & rx_ready_i.
  - If clear and load occur in the same cycle, load wins (new byte, valid stays 1).
  - rx_data_o is stable while rx_valid_o=1.
- TX stream: tx_ready_o is never asserted outside the WR_TX completion cycle. tx_valid_i dropping mid-WR_TX does not abort the write.
- Divider: cfg_div_i=0 is written as-is, with no clamping.

Optional Feature:
- Macro: UART_POLL_TIMEOUT_EN.
- Defined:
  - A 10-bit-or-wider cycle counter runs while uart_valid=1 and resets on each new request.
  - When the counter reaches TIMEOUT without ready: uart_valid drops, bus_err_o sets (sticky until rst), and the FSM goes to POLL_RX.
  - If the timeout hits during init, the FSM instead restarts at W_SRST1.
  - A timed-out read returns flag 0.
- Undefined: no counter; bus_err_o is tied to 0; the FSM waits on ready indefinitely.

Test Plan:
- Init: cfg_div_i=0x1B2 with a UART model giving ready 2 cycles after valid -> writes seen in order SOFTRESET=1, SOFTRESET=0, DIV=0x01B2 (wstrb=0b1100 at addr 2), TXEN=1, RXEN=1; init_done_o=1 after the 5th ready.
- RX: model RXREADY=1, RXDATA=0x41, rx_ready_i=1 -> rx_valid_o high 1 cycle with rx_data_o=0x41; next RXREADY poll follows a TX poll slot.
- RX backpressure: rx_ready_i=0 with 2 bytes pending -> first byte 0x41 held; no RXREADY reads issued until accept; second byte 0x42 delivered after accept.
- TX: tx_valid_i=1, tx_data_i=0x5A, TXREADY=0 twice then 1 -> 2 RX polls interleaved; TXDATA write wdata=0x5A<<0, wstrb=0b0001; one tx_ready_o pulse.
- Reset mid-WR_TX: rst=1 for 1 cycle while uart_valid=1 -> uart_valid=0, tx_ready_o=0, init_done_o=0 next cycle; sequence restarts with SOFTRESET=1.
- With UART_POLL_TIMEOUT_EN, TIMEOUT=15: model never asserts ready during POLL_RX -> uart_valid drops after 15 cycles, bus_err_o=1 and stays 1, polling continues.
